// File: rtl/uart_stream_pkg.sv
// Shared types, sync bytes and frame sizing for the UART sample streamer.
// CHECKSUM_EN follows the UART_STREAM_CHECKSUM_EN build macro.
package uart_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT
    } frame_state_t;

    localparam logic [7:0] SYNC0 = 8'h43;
    localparam logic [7:0] SYNC1 = 8'h48;

`ifdef UART_STREAM_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    function automatic int bytes_per_frame(input int n, input int w, input bit checksum_en);
        return 4 + n * (w / 8) + (checksum_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_sample_streamer_byte_tx.sv
// 8N1 byte transmitter: start bit, eight data bits LSB first, stop bit, BAUD_DIV clocks per bit.
module uart_byte_tx #(
    parameter int BAUD_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       active,
    output logic       done
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    shift_q, shift_d;
    logic          active_q, active_d;
    logic          tx_q, tx_d;
    logic          tick;

    // done is combinational so the frame FSM can queue the next byte with only one idle cycle
    always_comb begin
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        active_d = active_q;
        tx_d     = tx_q;
        tick     = active_q && (baud_q == CW'(BAUD_DIV - 1));
        done     = tick && (bit_q == 4'd9);
        if (!active_q) begin
            if (start) begin
                shift_d  = {1'b1, data, 1'b0};
                active_d = 1'b1;
                baud_d   = '0;
                bit_d    = 4'd0;
                tx_d     = 1'b0;
            end
        end else if (tick) begin
            baud_d = '0;
            if (bit_q == 4'd9) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                bit_d   = bit_q + 4'd1;
                tx_d    = shift_q[1];
                shift_d = {1'b1, shift_q[9:1]};
            end
        end else begin
            baud_d = baud_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= 10'h3FF;
            active_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            active_q <= active_d;
            tx_q     <= tx_d;
        end
    end

    assign tx     = tx_q;
    assign active = active_q;

endmodule

// File: rtl/uart_sample_streamer.sv
// Snapshots every channel on a sample_clk rising edge and ships the set as one framed UART packet.
// Define UART_STREAM_CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_sample_streamer
    import uart_stream_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int W          = 16,
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD       = 115200,
    parameter int DECIMATE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_clk,
    input  logic [N_CHANNELS*W-1:0] samples,
    output logic                    tx,
    output logic                    busy,
    output logic                    frame_led,
    output logic [7:0]              drop_count
);

    localparam int         BAUD_DIV    = CLK_FREQ / BAUD;
    localparam int         BPS         = W / 8;
    localparam int         FRAME_BYTES = bytes_per_frame(N_CHANNELS, W, CHECKSUM_EN);
    localparam logic [7:0] LAST_IDX    = 8'(FRAME_BYTES - 1);
    localparam logic [7:0] DEC_LAST    = 8'(DECIMATE - 1);
    localparam logic [7:0] N_BYTE      = 8'(N_CHANNELS);

    if (!(W == 8 || W == 16 || W == 24 || W == 32)) begin : g_w_check
        $error("uart_sample_streamer: W must be 8, 16, 24 or 32");
    end
    if (BAUD_DIV < 4) begin : g_div_check
        $error("uart_sample_streamer: CLK_FREQ/BAUD must be at least 4");
    end

    frame_state_t            state_q, state_d;
    logic                    sample_clk_q;
    logic                    edge_det;
    logic [N_CHANNELS*W-1:0] shadow_q, shadow_d;
    logic [7:0]              byte_idx_q, byte_idx_d;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              dec_q, dec_d;
    logic [7:0]              drop_q, drop_d;
    logic                    led_q, led_d;
    logic [7:0]              sample_byte;
    logic [7:0]              cur_byte;
    logic                    tx_start, tx_done, tx_active;

    assign edge_det = sample_clk & ~sample_clk_q;

    always_comb begin
        sample_byte = 8'h00;
        for (int ch = 0; ch < N_CHANNELS; ch++) begin
            for (int b = 0; b < BPS; b++) begin
                if (int'(byte_idx_q) == 4 + ch * BPS + b)
                    sample_byte = shadow_q[ch*W + (BPS-1-b)*8 +: 8];
            end
        end
    end

`ifdef UART_STREAM_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // The checksum byte XORs itself into the accumulator when sent; harmless, it is cleared in LOAD
    always_comb begin
        csum_d = csum_q;
        if (state_q == LOAD)
            csum_d = 8'h00;
        else if (state_q == SEND)
            csum_d = csum_q ^ cur_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= 8'h00;
        else     csum_q <= csum_d;
    end
`endif

    always_comb begin
        case (byte_idx_q)
            8'd0:    cur_byte = SYNC0;
            8'd1:    cur_byte = SYNC1;
            8'd2:    cur_byte = seq_q;
            8'd3:    cur_byte = N_BYTE;
            default: cur_byte = sample_byte;
        endcase
`ifdef UART_STREAM_CHECKSUM_EN
        if (byte_idx_q == LAST_IDX)
            cur_byte = csum_q;
`endif
    end

    // busy covers LOAD..WAIT, so an edge in the cycle the last byte finishes is still a drop
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        byte_idx_d = byte_idx_q;
        seq_d      = seq_q;
        dec_d      = dec_q;
        drop_d     = drop_q;
        led_d      = led_q;
        tx_start   = 1'b0;
        if (edge_det && state_q != IDLE && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
        case (state_q)
            IDLE: begin
                if (edge_det) begin
                    if (dec_q == DEC_LAST) begin
                        dec_d   = 8'd0;
                        state_d = LOAD;
                    end else begin
                        dec_d = dec_q + 8'd1;
                    end
                end
            end
            LOAD: begin
                shadow_d   = samples;
                byte_idx_d = 8'd0;
                state_d    = SEND;
            end
            SEND: begin
                tx_start = !tx_active;
                state_d  = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        led_d   = ~led_q;
                        seq_d   = seq_q + 8'd1;
                    end else begin
                        byte_idx_d = byte_idx_q + 8'd1;
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sample_clk_q <= 1'b0;
            shadow_q     <= '0;
            byte_idx_q   <= 8'd0;
            seq_q        <= 8'd0;
            dec_q        <= 8'd0;
            drop_q       <= 8'd0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_clk_q <= sample_clk;
            shadow_q     <= shadow_d;
            byte_idx_q   <= byte_idx_d;
            seq_q        <= seq_d;
            dec_q        <= dec_d;
            drop_q       <= drop_d;
            led_q        <= led_d;
        end
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start),
        .data  (cur_byte),
        .tx    (tx),
        .active(tx_active),
        .done  (tx_done)
    );

    assign busy       = (state_q != IDLE);
    assign frame_led  = led_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_sample_streamer.sv
// Self-checking bench: decodes the UART line and scores every byte against a frame-level model.
module tb_uart_sample_streamer;
    import uart_stream_pkg::CHECKSUM_EN;

    localparam int N_CH      = 4;
    localparam int W         = 16;
    localparam int PW        = N_CH * W;
    localparam int BAUD_DIV  = 4;
    localparam int FRAME_LEN = 4 + PW / 8 + (CHECKSUM_EN ? 1 : 0);

    typedef struct {
        logic [PW-1:0] samples;
        logic [PW-1:0] payload;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          sample_clk0, sample_clk1;
    logic [PW-1:0] samples0, samples1;
    logic          tx0, tx1, busy0, busy1, led0, led1;
    logic [7:0]    drop0, drop1;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         rst_events = 0;
    int         rx_cnt0 = 0;
    int         rx_cnt1 = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_seq0 = 8'd0;
    logic [7:0] exp_seq1 = 8'd0;
    int         exp_drop0 = 0;
    int         exp_drop1 = 0;
    logic       exp_led0 = 1'b0;
    logic       exp_led1 = 1'b0;
    int         dec_edges = 0;
    vec_t       vecs[4];

    uart_sample_streamer #(
        .N_CHANNELS(N_CH), .W(W), .CLK_FREQ(12_000_000), .BAUD(3_000_000), .DECIMATE(1)
    ) dut0 (
        .clk(clk), .rst(rst), .sample_clk(sample_clk0), .samples(samples0),
        .tx(tx0), .busy(busy0), .frame_led(led0), .drop_count(drop0)
    );

    uart_sample_streamer #(
        .N_CHANNELS(N_CH), .W(W), .CLK_FREQ(12_000_000), .BAUD(3_000_000), .DECIMATE(3)
    ) dut1 (
        .clk(clk), .rst(rst), .sample_clk(sample_clk1), .samples(samples1),
        .tx(tx1), .busy(busy1), .frame_led(led1), .drop_count(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge rst) rst_events++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] samplesToPayload(input logic [PW-1:0] s);
        logic [PW-1:0] p;
        p = '0;
        for (int ch = 0; ch < N_CH; ch++)
            p[(N_CH-1-ch)*W +: W] = s[ch*W +: W];
        return p;
    endfunction

    // Frame = 'C','H',seq,N, payload bytes (channel 0 first, each MSB first), optional XOR byte
    task automatic expectFrame(input int which, input logic [7:0] seq, input logic [PW-1:0] payload);
        logic [7:0] frm[$];
        logic [7:0] x;
        frm = {8'h43, 8'h48, seq, 8'(N_CH)};
        for (int i = PW/8 - 1; i >= 0; i--)
            frm.push_back(payload[i*8 +: 8]);
        if (CHECKSUM_EN) begin
            x = 8'h00;
            foreach (frm[i]) x = x ^ frm[i];
            frm.push_back(x);
        end
        foreach (frm[i]) begin
            if (which == 0) exp_q0.push_back(frm[i]);
            else            exp_q1.push_back(frm[i]);
        end
    endtask

    task automatic deliver(input int which, input logic [7:0] b);
        logic [7:0] e;
        if ((which == 0 && exp_q0.size() == 0) || (which == 1 && exp_q1.size() == 0)) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL rx%0d_unexpected: got 0x%02h, expected no byte", which, b);
        end else begin
            e = (which == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            checkOutput($sformatf("rx%0d_byte%0d", which, (which == 0) ? rx_cnt0 : rx_cnt1), {24'd0, b}, {24'd0, e});
        end
        if (which == 0) rx_cnt0++;
        else            rx_cnt1++;
    endtask

    // Mid-bit sampler; a byte interrupted by reset is discarded
    task automatic rxLoop(input int which);
        logic [7:0] b;
        logic       line;
        logic       start_ok;
        int         rs;
        forever begin
            @(negedge clk);
            line = (which == 0) ? tx0 : tx1;
            if (!rst && line == 1'b0) begin
                rs = rst_events;
                b  = 8'h00;
                repeat (2) @(negedge clk);
                start_ok = (((which == 0) ? tx0 : tx1) === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) @(negedge clk);
                    b[i] = (which == 0) ? tx0 : tx1;
                end
                repeat (BAUD_DIV) @(negedge clk);
                line = (which == 0) ? tx0 : tx1;
                if (rs == rst_events && !rst) begin
                    if (!start_ok || line !== 1'b1) begin
                        n_cmp++;
                        n_fail++;
                        $display("[TB] FAIL rx%0d_framing: start_ok=%0b stop=%0b, expected 1 and 1", which, start_ok, line);
                    end else begin
                        deliver(which, b);
                    end
                end
            end
        end
    endtask

    initial rxLoop(0);
    initial rxLoop(1);

    // One sample_clk pulse on dut0; the model decides drop vs new frame from busy at the edge
    task automatic applyStimulus(input logic [PW-1:0] s, input logic [PW-1:0] payload);
        @(negedge clk);
        samples0 = s;
        if (busy0) begin
            if (exp_drop0 < 255) exp_drop0++;
        end else begin
            expectFrame(0, exp_seq0, payload);
            exp_seq0++;
            exp_led0 = ~exp_led0;
        end
        sample_clk0 = 1'b1;
        @(negedge clk);
        sample_clk0 = 1'b0;
    endtask

    task automatic applyStimulusDec(input logic [PW-1:0] s);
        @(negedge clk);
        samples1 = s;
        if (busy1) begin
            if (exp_drop1 < 255) exp_drop1++;
        end else begin
            dec_edges++;
            if (dec_edges % 3 == 0) begin
                expectFrame(1, exp_seq1, samplesToPayload(s));
                exp_seq1++;
                exp_led1 = ~exp_led1;
            end
        end
        sample_clk1 = 1'b1;
        @(negedge clk);
        sample_clk1 = 1'b0;
    endtask

    task automatic waitIdle(input int which);
        int cnt;
        cnt = 0;
        while (((which == 0) ? busy0 : busy1) && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 3000) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL idle_timeout%0d: busy still 1 after %0d cycles, expected 0", which, cnt);
        end
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [PW-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [PW-1:0] s;
        rst = 1'b1;
        sample_clk0 = 1'b0;
        sample_clk1 = 1'b0;
        samples0 = '0;
        samples1 = '0;
        vecs[0] = '{samples: 64'h7FFF_8000_ABCD_1234, payload: 64'h1234_ABCD_8000_7FFF};
        vecs[1] = '{samples: 64'h0000_0000_0000_0000, payload: 64'h0000_0000_0000_0000};
        vecs[2] = '{samples: 64'hFFFF_0001_00FF_FF00, payload: 64'hFF00_00FF_0001_FFFF};
        vecs[3] = '{samples: 64'h0102_0304_0506_0708, payload: 64'h0708_0506_0304_0102};

        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx0, 1);
        checkOutput("reset_busy", busy0, 0);
        checkOutput("reset_led", led0, 0);
        checkOutput("reset_drop", drop0, 0);
        checkOutput("reset_tx_dec", tx1, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] single frame with latency");
        applyStimulus(vecs[0].samples, vecs[0].payload);
        checkOutput("busy_after_edge", busy0, 1);
        @(negedge clk);
        checkOutput("tx_before_start", tx0, 1);
        @(negedge clk);
        checkOutput("tx_start_bit", tx0, 0);
        waitIdle(0);
        checkOutput("first_busy_done", busy0, 0);
        checkOutput("first_led", led0, exp_led0);
        checkOutput("first_drop", drop0, 0);

        $display("[TB] table vectors with mid-frame sample changes");
        for (int i = 1; i < 4; i++) begin
            applyStimulus(vecs[i].samples, vecs[i].payload);
            @(negedge clk);
            samples0 = rnd();
            waitIdle(0);
            checkOutput($sformatf("vec%0d_led", i), led0, exp_led0);
        end

        $display("[TB] random frames");
        for (int i = 0; i < 4; i++) begin
            s = rnd();
            applyStimulus(s, samplesToPayload(s));
            repeat (50) @(negedge clk);
            samples0 = rnd();
            waitIdle(0);
        end
        checkOutput("rand_led", led0, exp_led0);

        $display("[TB] overrun");
        s = rnd();
        applyStimulus(s, samplesToPayload(s));
        repeat (100) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rnd(), '0);
            repeat (18) @(negedge clk);
        end
        waitIdle(0);
        checkOutput("overrun_drop", drop0, exp_drop0);
        repeat (60) @(negedge clk);
        checkOutput("overrun_no_restart", busy0, 0);
        checkOutput("overrun_queue", exp_q0.size(), 0);

        $display("[TB] random edge storm to saturate drop_count");
        for (int i = 0; i < 320; i++) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            s = rnd();
            applyStimulus(s, samplesToPayload(s));
            if (i % 40 == 39) checkOutput($sformatf("storm_drop%0d", i), drop0, exp_drop0);
        end
        waitIdle(0);
        checkOutput("storm_drop_final", drop0, exp_drop0);
        checkOutput("storm_saturated", drop0, 255);
        checkOutput("storm_led", led0, exp_led0);

        $display("[TB] decimation by 3");
        for (int i = 0; i < 6; i++) begin
            applyStimulusDec(rnd());
            repeat (10) @(negedge clk);
            waitIdle(1);
        end
        checkOutput("dec_drop", drop1, exp_drop1);
        checkOutput("dec_led", led1, exp_led1);
        checkOutput("dec_queue", exp_q1.size(), 0);
        checkOutput("dec_frames", rx_cnt1, 2 * FRAME_LEN);

        $display("[TB] reset during the fifth byte");
        repeat (5) @(negedge clk);
        s = rnd();
        applyStimulus(s, samplesToPayload(s));
        repeat (167) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_tx", tx0, 1);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_drop", drop0, 0);
        checkOutput("rst_led", led0, 0);
        checkOutput("rst_bytes_sent", exp_q0.size(), FRAME_LEN - 4);
        exp_q0.delete();
        exp_seq0 = 8'd0;
        exp_drop0 = 0;
        exp_led0 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        s = rnd();
        applyStimulus(s, samplesToPayload(s));
        waitIdle(0);
        checkOutput("post_rst_drop", drop0, 0);
        checkOutput("post_rst_led", led0, exp_led0);
        checkOutput("final_queue0", exp_q0.size(), 0);
        checkOutput("final_queue1", exp_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
